// File: rtl/mac_accumulator_if.sv
// Product-in / result-out bundle between the MAC pipeline, the accumulator and its consumer.
// master: pipeline + consumer side; slave: accumulator side.
interface mac_accumulator_if #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 40
);
  logic signed [PROD_W-1:0] prodIn;
  logic                     NOPIn;
  logic                     resReady;
  logic signed [ACC_W-1:0]  resOut;
  logic                     resValid;
  logic                     accBusy;
  logic                     ovfErr;

  modport master (
    output prodIn, NOPIn, resReady,
    input  resOut, resValid, accBusy, ovfErr
  );

  modport slave (
    input  prodIn, NOPIn, resReady,
    output resOut, resValid, accBusy, ovfErr
  );
endinterface

// File: rtl/mac_accumulator.sv
// Dot-product accumulator: sums LEN non-NOP products into a 1-entry valid/ready result register (result 1 cycle after last product).
// Never stalls upstream; a completion that finds the result register full is dropped and flagged sticky. MAC_ACC_SAT_EN: saturating adds.
module mac_accumulator #(
  parameter int PROD_W = 16,
  parameter int ACC_W  = 40,
  parameter int LEN    = 8
) (
  input  logic               clk,
  input  logic               aclr,
  input  logic               sclr,
  mac_accumulator_if.slave   bus
);
  localparam int CNT_W = $clog2(LEN + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(LEN - 1);

  typedef enum logic {IDLE, ACCUM} state_t;

  state_t                  state, state_nxt;
  logic signed [ACC_W-1:0] acc, acc_nxt;
  logic signed [ACC_W-1:0] ext_prod, sum;
  logic signed [ACC_W-1:0] res_dat, res_dat_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    res_vld, res_vld_nxt;
  logic                    ovf, ovf_nxt;

  assign ext_prod = {{(ACC_W - PROD_W){bus.prodIn[PROD_W-1]}}, bus.prodIn};

`ifdef MAC_ACC_SAT_EN
  localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W - 1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W - 1){1'b0}}};
  logic signed [ACC_W:0] sum_wide;

  // One guard bit: the two top bits disagree exactly when the sum left the ACC_W range.
  always_comb begin
    sum_wide = {acc[ACC_W-1], acc} + {ext_prod[ACC_W-1], ext_prod};
    if (sum_wide[ACC_W] != sum_wide[ACC_W-1])
      sum = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
    else
      sum = sum_wide[ACC_W-1:0];
  end
`else
  assign sum = acc + ext_prod;
`endif

  always_comb begin
    state_nxt   = state;
    acc_nxt     = acc;
    cnt_nxt     = cnt;
    res_dat_nxt = res_dat;
    res_vld_nxt = res_vld;
    ovf_nxt     = ovf;

    if (res_vld && bus.resReady)
      res_vld_nxt = 1'b0;

    if (!bus.NOPIn) begin
      if (cnt == LAST_CNT) begin
        acc_nxt   = '0;
        cnt_nxt   = '0;
        state_nxt = IDLE;
        if (!res_vld || bus.resReady) begin
          res_dat_nxt = sum;
          res_vld_nxt = 1'b1;
        end else begin
          ovf_nxt = 1'b1;
        end
      end else begin
        acc_nxt   = sum;
        cnt_nxt   = cnt + CNT_W'(1);
        state_nxt = ACCUM;
      end
    end
  end

  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      res_dat <= '0;
      res_vld <= 1'b0;
      ovf     <= 1'b0;
    end else if (sclr) begin
      state   <= IDLE;
      acc     <= '0;
      cnt     <= '0;
      res_dat <= '0;
      res_vld <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      state   <= state_nxt;
      acc     <= acc_nxt;
      cnt     <= cnt_nxt;
      res_dat <= res_dat_nxt;
      res_vld <= res_vld_nxt;
      ovf     <= ovf_nxt;
    end
  end

  assign bus.resOut   = res_dat;
  assign bus.resValid = res_vld;
  assign bus.accBusy  = (state == ACCUM);
  assign bus.ovfErr   = ovf;
endmodule

// File: doc/mac_accumulator.md
# mac_accumulator

Downstream consumer of the MAC multiply pipeline and its matching NOP pipeline. Each cycle it takes one signed product and the delayed NOP flag. It sums the non-NOP products of each dot product of fixed length `LEN` and presents every completed sum on a single-entry valid/ready output register. NOP cycles are bubbles: they are never accumulated and never counted.

## Interface
- `PROD_W`, 16: width of the signed product input.
- `ACC_W`, 40: width of the signed accumulator and result; must be ≥ `PROD_W`.
- `LEN`, 8: non-NOP products per dot product; must be ≥ 1.

- `clk`  in  1  clock; all state updates on the rising edge.
- `aclr`  in  1  asynchronous, active-high reset.
- `sclr`  in  1  synchronous clear, active-high; same effect as `aclr`, applied at the edge.
- `prodIn`  in  `PROD_W`  signed product from the multiply pipeline.
- `NOPIn`  in  1  NOP flag from the NOP pipeline output; 1 = bubble, 0 = valid product.
- `resReady`  in  1  downstream accepts the result.
- `resOut`  out  `ACC_W`  completed signed dot-product sum.
- `resValid`  out  1  `resOut` holds an unconsumed result.
- `accBusy`  out  1  partial sum in progress (state ACCUM).
- `ovfErr`  out  1  sticky flag: a completed result was dropped.

## Operation
- Internal state: accumulator `acc` (`ACC_W`), product counter `cnt` (`$clog2(LEN+1)` bits), FSM {IDLE, ACCUM}.
- `prodIn` is sign-extended to `ACC_W` before addition. Let `sum = acc + ext(prodIn)`.
- `NOPIn=1`: `acc`, `cnt` and the FSM hold.
- `NOPIn=0` with `cnt < LEN-1`: `acc <= sum`, `cnt <= cnt+1`, FSM → ACCUM.
- `NOPIn=0` with `cnt == LEN-1` (completion):
  - Load the result, `acc <= 0`, `cnt <= 0`, FSM → IDLE.
  - If the output register is free, or is being consumed this edge: `resOut <= sum`, `resValid <= 1`.
  - Otherwise (`resValid=1` and `resReady=0`): discard `sum`, keep `resOut`, set `ovfErr <= 1`.
- With `LEN=1`, every valid product completes immediately: `resOut = ext(prodIn)`. The FSM never leaves IDLE.
- Output handshake: a transfer occurs at an edge where `resValid && resReady`. Without a new completion, `resValid <= 0` after the transfer. `resOut` stays stable while `resValid=1`.
- `accBusy = (state == ACCUM)`.
- `ovfErr` clears only on `aclr` or `sclr`.
- Priority: `aclr` > `sclr` > normal operation.

## Timing
- Reset values (`aclr` immediately, `sclr` at the next edge): `resOut=0`, `resValid=0`, `accBusy=0`, `ovfErr=0`, `acc=0`, `cnt=0`, FSM=IDLE.
- Latency: `resValid` rises at the edge that samples the LEN-th valid product, so the result is visible one cycle after that product is presented.
- Throughput: one product per cycle with no stalls. The block never backpressures upstream, because the pipeline cannot stall.
- Completion coinciding with a handshake: the old result transfers, the new one loads, and `resValid` stays 1 (back-to-back results, no bubble).
- Reset mid-operation: the partial sum is lost, and the next valid product starts a fresh dot product.
- `resReady` is ignored while `resValid=0`.

## Configuration
- `MAC_ACC_SAT_EN` defined: every addition (partial and final) saturates to the signed `ACC_W` range. Positive overflow clamps to 2^(ACC_W-1)-1; negative overflow clamps to -2^(ACC_W-1).
- `MAC_ACC_SAT_EN` undefined: two's-complement wrap-around modulo 2^ACC_W, with no overflow detection.

## Test plan
All scenarios use `LEN=4`, `PROD_W=16`, `ACC_W=40` unless stated.
- Products 1, 2, 3, 4 on consecutive cycles, `NOPIn=0`, `resReady=1` → `resValid=1` for one cycle after the 4th product, `resOut=10`, `accBusy` back to 0.
- Stream 5, NOP, NOP, −7, 3, NOP, 2 → exactly one result `resOut=3`. NOP cycles change neither `acc` nor `cnt`.
- `resReady=0`; two full dot products (1,1,1,1 then 2,2,2,2) → `resOut` stays 4, `resValid` stays 1, `ovfErr=1`. Raising `resReady` transfers 4, then `resValid=0`.
- Two back-to-back dot products with `resReady=1` on the completion edge → `resValid` stays high across both results (4, then 8).
- Assert `aclr` after two of four products → all outputs 0 without waiting for an edge. Then 1, 1, 1, 1 → `resOut=4`.
- `ACC_W=17`, products 32767 ×4 → `resOut=65535` with `MAC_ACC_SAT_EN`, `resOut=−4` without it.
